// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and limits for the arb_muxn selector
package mux_pkg;

    typedef enum logic {MODE_SEL, MODE_RR} mux_mode_t;

    localparam int NCH_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin search for the first requester after ptr
module rr_pick #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] cand;

    // Walk ptr+1, ptr+2, ... with an explicit wrap so non-power-of-2 NCH never visits idx >= NCH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = ptr;
        for (int k = 0; k < NCH; k++) begin
            cand = (cand == SELW'(NCH - 1)) ? '0 : cand + SELW'(1);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/arb_muxn.sv
// rtl/arb_muxn.sv - NCH-way selector/arbiter with valid/ready and one output register
module arb_muxn
    import mux_pkg::*;
#(
    parameter  int NB   = 32,
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  mux_mode_t         mode,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH*NB-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [NB-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_idx,
    output logic              sel_err,
    input  logic              err_clr
);

    if (NCH < 2 || NCH > NCH_MAX) begin : g_bad_nch
        $error("arb_muxn: NCH out of range");
    end

    logic            load_en;
    logic            sel_ok;
    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    logic [SELW-1:0] ptr;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [NB-1:0]   gnt_data;

    assign load_en = !out_valid || out_ready;
    assign sel_ok  = 32'(sel) < 32'(NCH);

    rr_pick #(.NCH(NCH)) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else if (sel_ok && in_valid[sel]) begin
            gnt_vld = 1'b1;
            gnt_idx = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        if (load_en && gnt_vld) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_data = in_data[gnt_idx*NB +: NB];

    // Pointer follows every grant, including explicit selects, so RR resumes fairly after a mode switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (load_en) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_idx   <= gnt_idx;
                ptr       <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (mode == MODE_SEL && !sel_ok) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_muxn.sv
// tb/tb_arb_muxn.sv - directed self-checking bench for arb_muxn (NCH=4 and NCH=3)
module tb_arb_muxn;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NCH=4 instance
    mux_mode_t    mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic         sel_err;
    logic         err_clr;

    // NCH=3 instance
    mux_mode_t    mode3;
    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_idx3;
    logic         sel_err3;
    logic         err_clr3;

    int checks = 0;
    int passed = 0;

    logic [31:0] word [4];

    arb_muxn #(.NB(32), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .sel_err(sel_err), .err_clr(err_clr)
    );

    arb_muxn #(.NB(32), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_idx(out_idx3), .sel_err(sel_err3), .err_clr(err_clr3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        mode = MODE_SEL; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b1; err_clr = 1'b0;
        mode3 = MODE_SEL; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1; err_clr3 = 1'b0;
        word[0] = 32'hCAFE_0000; word[1] = 32'hCAFE_0001;
        word[2] = 32'hDEAD_BEEF; word[3] = 32'hCAFE_0003;
        in_data  = {word[3], word[2], word[1], word[0]};
        in_data3 = {word[2], word[1], word[0]};
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({out_valid, out_data, out_idx, sel_err} !== 36'h0)
            $display("FAIL reset_outputs: got v=%b d=%h i=%0d e=%b, want all 0", out_valid, out_data, out_idx, sel_err);
        else passed++;
        checks++;
        if ({out_valid3, sel_err3} !== 2'b00)
            $display("FAIL reset_outputs3: got v=%b e=%b, want 0 0", out_valid3, sel_err3);
        else passed++;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_sel_basic();
        mode = MODE_SEL; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) $display("FAIL sel_in_ready: got %b want 0100", in_ready);
        else passed++;
        step();
        checks++;
        if ({out_valid, out_idx, out_data} !== {1'b1, 2'd2, 32'hDEAD_BEEF})
            $display("FAIL sel_out: got v=%b i=%0d d=%h want 1 2 deadbeef", out_valid, out_idx, out_data);
        else passed++;
    endtask

    task automatic test_bubble();
        in_valid = 4'b0000;
        step();
        checks++;
        if ({out_valid, out_idx, out_data} !== {1'b0, 2'd2, 32'hDEAD_BEEF})
            $display("FAIL bubble_hold: got v=%b i=%0d d=%h want 0 2 deadbeef", out_valid, out_idx, out_data);
        else passed++;
    endtask

    task automatic test_rr_stream();
        logic [1:0] exp;
        mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp = 2'(k % 4);
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp))
                $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready, 4'b0001 << exp);
            else passed++;
            step();
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, exp, word[exp]})
                $display("FAIL rr_out[%0d]: got v=%b i=%0d d=%h want 1 %0d %h", k, out_valid, out_idx, out_data, exp, word[exp]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, in_ready);
            else passed++;
            step();
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, 2'd0, word[0]})
                $display("FAIL bp_hold[%0d]: got v=%b i=%0d d=%h want 1 0 %h", k, out_valid, out_idx, out_data, word[0]);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", in_ready);
        else passed++;
        step();
        checks++;
        if (out_idx !== 2'd1) $display("FAIL bp_release_idx: got %0d want 1", out_idx);
        else passed++;
    endtask

    task automatic test_sel_err();
        mode3 = MODE_SEL; sel3 = 2'b11; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) $display("FAIL selerr_in_ready: got %b want 000", in_ready3);
        else passed++;
        step();
        checks++;
        if (sel_err3 !== 1'b1) $display("FAIL selerr_set: got %b want 1", sel_err3);
        else passed++;
        err_clr3 = 1'b1;
        step();
        checks++;
        if (sel_err3 !== 1'b1) $display("FAIL selerr_set_priority: got %b want 1", sel_err3);
        else passed++;
        sel3 = 2'd0;
        step();
        checks++;
        if (sel_err3 !== 1'b0) $display("FAIL selerr_clear: got %b want 0", sel_err3);
        else passed++;
        err_clr3 = 1'b0; in_valid3 = 3'b000;
        checks++;
        if (sel_err !== 1'b0) $display("FAIL selerr_pow2: got %b want 0", sel_err);
        else passed++;
    endtask

    task automatic test_async_reset();
        mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_idx, out_data} !== 35'h0)
            $display("FAIL async_reset: got v=%b i=%0d d=%h want 0 0 0", out_valid, out_idx, out_data);
        else passed++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) $display("FAIL post_reset_ready: got %b want 0001", in_ready);
        else passed++;
        step();
        checks++;
        if ({out_valid, out_idx} !== {1'b1, 2'd0})
            $display("FAIL post_reset_grant: got v=%b i=%0d want 1 0", out_valid, out_idx);
        else passed++;
    endtask

    task automatic test_mode_switch();
        mode = MODE_SEL; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) $display("FAIL switch_sel_ready: got %b want 1000", in_ready);
        else passed++;
        step();
        checks++;
        if (out_idx !== 2'd3) $display("FAIL switch_sel_idx: got %0d want 3", out_idx);
        else passed++;
        mode = MODE_RR; in_valid = 4'b1001;
        #1;
        checks++;
        if (in_ready !== 4'b0001) $display("FAIL switch_rr_ready: got %b want 0001", in_ready);
        else passed++;
        step();
        checks++;
        if ({out_idx, out_data} !== {2'd0, word[0]})
            $display("FAIL switch_rr_out: got i=%0d d=%h want 0 %h", out_idx, out_data, word[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_bubble();
        apply_reset();
        test_rr_stream();
        test_backpressure();
        test_sel_err();
        test_async_reset();
        test_mode_switch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
